// File: rtl/stack_ctrl_if.sv
// rtl/stack_ctrl_if.sv - request/response and pointer/RAM datapath signals for stack_ctrl
interface stack_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic                  Push;
  logic                  Pop;
  logic                  Clear;
  logic [DATA_WIDTH-1:0] DataIn;
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  Ack;
  logic                  Err;
  logic                  Busy;
  logic                  Full;
  logic                  Empty;
  logic                  CntD;
  logic                  CntE;
  logic                  CntRst;
  logic [ADDR_WIDTH-1:0] Sp;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic                  MemWe;
  logic [DATA_WIDTH-1:0] MemWdata;
  logic [DATA_WIDTH-1:0] MemRdata;

  // master: the requester together with the pointer counter and RAM it controls
  modport master (
    output Push, Pop, Clear, DataIn, Sp, MemRdata,
    input  DataOut, Ack, Err, Busy, Full, Empty, CntD, CntE, CntRst,
           MemAddr, MemWe, MemWdata
  );

  modport slave (
    input  Push, Pop, Clear, DataIn, Sp, MemRdata,
    output DataOut, Ack, Err, Busy, Full, Empty, CntD, CntE, CntRst,
           MemAddr, MemWe, MemWdata
  );
endinterface

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - push/pop/clear sequencer for an up/down pointer counter and single-port stack RAM
module stack_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input logic      Clk,
  input logic      Rst,
  stack_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP_DEC,
    S_POP_RD,
    S_POP_OUT,
    S_CLEAR,
    S_REJECT
  } state_t;

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ack;
  logic                  err;
  logic                  cnt_e;
  logic                  cnt_d;
  logic                  mem_we;
  logic                  full;
  logic                  empty;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Strobes are registered on entry so they coincide exactly with their state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= S_IDLE;
      count    <= '0;
      hold     <= '0;
      data_out <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      cnt_e    <= 1'b0;
      cnt_d    <= 1'b0;
      mem_we   <= 1'b0;
    end else begin
      ack    <= 1'b0;
      err    <= 1'b0;
      cnt_e  <= 1'b0;
      cnt_d  <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.Clear) begin
            state <= S_CLEAR;
            ack   <= 1'b1;
          end else if (bus.Pop) begin
            if (empty) begin
              state <= S_REJECT;
              ack   <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= S_POP_DEC;
              cnt_e <= 1'b1;
            end
          end else if (bus.Push) begin
            if (full) begin
              state <= S_REJECT;
              ack   <= 1'b1;
              err   <= 1'b1;
            end else begin
              state  <= S_PUSH;
              hold   <= bus.DataIn;
              mem_we <= 1'b1;
              cnt_e  <= 1'b1;
              cnt_d  <= 1'b1;
              ack    <= 1'b1;
            end
          end
        end
        S_PUSH: begin
          count <= count + ONE;
          state <= S_IDLE;
        end
        S_POP_DEC: begin
          count <= count - ONE;
          state <= S_POP_RD;
        end
        S_POP_RD: begin
          state <= S_POP_OUT;
          ack   <= 1'b1;
        end
        S_POP_OUT: begin
          data_out <= bus.MemRdata;
          state    <= S_IDLE;
        end
        S_CLEAR: begin
          count <= '0;
          state <= S_IDLE;
        end
        S_REJECT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.CntRst   = Rst || (state == S_CLEAR);
  assign bus.CntE     = cnt_e;
  assign bus.CntD     = cnt_d;
  assign bus.MemAddr  = bus.Sp;
  assign bus.MemWe    = mem_we;
  assign bus.MemWdata = hold;
  assign bus.DataOut  = data_out;
  assign bus.Ack      = ack;
  assign bus.Err      = err;
  assign bus.Busy     = (state != S_IDLE);
  assign bus.Full     = full;
  assign bus.Empty    = empty;
endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed self-checking bench for stack_ctrl with a pointer-counter and RAM model
module tb_stack_ctrl;
  localparam int AW = 2;
  localparam int DW = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  stack_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  stack_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  logic [AW-1:0] sp;
  logic [DW-1:0] mem [4];
  logic [DW-1:0] rdata;

  always @(posedge Clk or posedge Rst) begin
    if (Rst)             sp <= '0;
    else if (bus.CntRst) sp <= '0;
    else if (bus.CntE)   sp <= bus.CntD ? sp + 2'd1 : sp - 2'd1;
  end

  always @(posedge Clk) begin
    if (bus.MemWe) mem[bus.MemAddr] <= bus.MemWdata;
    rdata <= mem[bus.MemAddr];
  end

  assign bus.Sp       = sp;
  assign bus.MemRdata = rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input logic [7:0] d, input int addr, input bit rej);
    bus.Push   = 1'b1;
    bus.DataIn = d;
    @(negedge Clk);
    chk("push_ack", 32'(bus.Ack), 1);
    chk("push_err", 32'(bus.Err), 32'(rej));
    chk("push_we", 32'(bus.MemWe), 32'(!rej));
    chk("push_cnte", 32'(bus.CntE), 32'(!rej));
    chk("push_cntd", 32'(bus.CntD), 32'(!rej));
    if (!rej) begin
      chk("push_addr", 32'(bus.MemAddr), 32'(addr));
      chk("push_wdata", 32'(bus.MemWdata), 32'(d));
    end
    bus.Push = 1'b0;
    @(negedge Clk);
    chk("push_ack_low", 32'(bus.Ack), 0);
    chk("push_idle", 32'(bus.Busy), 0);
  endtask

  task automatic pop_op(input int addr, input logic [7:0] d, input bit rej, input bit with_push);
    bus.Pop  = 1'b1;
    bus.Push = with_push;
    @(negedge Clk);
    bus.Pop  = 1'b0;
    bus.Push = 1'b0;
    if (rej) begin
      chk("pop_rej_ack", 32'(bus.Ack), 1);
      chk("pop_rej_err", 32'(bus.Err), 1);
      chk("pop_rej_cnte", 32'(bus.CntE), 0);
    end else begin
      chk("pop_dec_ack", 32'(bus.Ack), 0);
      chk("pop_dec_cnte", 32'(bus.CntE), 1);
      chk("pop_dec_cntd", 32'(bus.CntD), 0);
      chk("pop_dec_we", 32'(bus.MemWe), 0);
      @(negedge Clk);
      chk("pop_rd_ack", 32'(bus.Ack), 0);
      chk("pop_rd_addr", 32'(bus.MemAddr), 32'(addr));
      @(negedge Clk);
      chk("pop_out_ack", 32'(bus.Ack), 1);
      chk("pop_out_err", 32'(bus.Err), 0);
    end
    @(negedge Clk);
    chk("pop_data", 32'(bus.DataOut), 32'(d));
    chk("pop_ack_low", 32'(bus.Ack), 0);
  endtask

  initial begin
    bus.Push   = 1'b0;
    bus.Pop    = 1'b0;
    bus.Clear  = 1'b0;
    bus.DataIn = '0;
    @(negedge Clk);
    chk("rst_cntrst", 32'(bus.CntRst), 1);
    chk("rst_empty", 32'(bus.Empty), 1);
    chk("rst_full", 32'(bus.Full), 0);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_ack", 32'(bus.Ack), 0);
    chk("rst_dout", 32'(bus.DataOut), 0);
    Rst = 1'b0;
    @(negedge Clk);
    chk("cntrst_rel", 32'(bus.CntRst), 0);

    push_op(8'h11, 0, 1'b0);
    push_op(8'h22, 1, 1'b0);
    push_op(8'h33, 2, 1'b0);
    chk("not_full_3", 32'(bus.Full), 0);
    push_op(8'h44, 3, 1'b0);
    chk("full_4", 32'(bus.Full), 1);
    chk("sp_wrap", 32'(sp), 0);

    push_op(8'h55, 0, 1'b1);
    chk("full_after_rej", 32'(bus.Full), 1);
    chk("sp_after_rej", 32'(sp), 0);

    pop_op(3, 8'h44, 1'b0, 1'b0);
    chk("not_full_pop", 32'(bus.Full), 0);
    pop_op(2, 8'h33, 1'b0, 1'b0);
    pop_op(1, 8'h22, 1'b0, 1'b0);
    pop_op(0, 8'h11, 1'b0, 1'b0);
    chk("empty_4pop", 32'(bus.Empty), 1);
    pop_op(0, 8'h11, 1'b1, 1'b0);
    chk("empty_rej", 32'(bus.Empty), 1);

    push_op(8'hAA, 0, 1'b0);
    push_op(8'hBB, 1, 1'b0);
    pop_op(1, 8'hBB, 1'b0, 1'b1);
    chk("pp_sp", 32'(sp), 1);
    chk("pp_empty", 32'(bus.Empty), 0);

    bus.Clear = 1'b1;
    bus.Pop   = 1'b1;
    @(negedge Clk);
    bus.Clear = 1'b0;
    bus.Pop   = 1'b0;
    chk("clr_ack", 32'(bus.Ack), 1);
    chk("clr_err", 32'(bus.Err), 0);
    chk("clr_cntrst", 32'(bus.CntRst), 1);
    chk("clr_cnte", 32'(bus.CntE), 0);
    @(negedge Clk);
    chk("clr_cntrst_low", 32'(bus.CntRst), 0);
    chk("clr_empty", 32'(bus.Empty), 1);
    chk("clr_sp", 32'(sp), 0);

    push_op(8'hCC, 0, 1'b0);
    push_op(8'hDD, 1, 1'b0);
    bus.Pop = 1'b1;
    @(negedge Clk);
    bus.Pop = 1'b0;
    chk("mid_popdec", 32'(bus.CntE), 1);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk("mid_busy", 32'(bus.Busy), 0);
    chk("mid_empty", 32'(bus.Empty), 1);
    chk("mid_cntrst", 32'(bus.CntRst), 1);
    chk("mid_dout", 32'(bus.DataOut), 0);
    chk("mid_ack", 32'(bus.Ack), 0);
    @(negedge Clk);
    chk("mid_ack2", 32'(bus.Ack), 0);
    Rst = 1'b0;
    @(negedge Clk);
    chk("mid_ack3", 32'(bus.Ack), 0);
    chk("mid_sp", 32'(sp), 0);

    bus.Push   = 1'b1;
    bus.DataIn = 8'h77;
    @(negedge Clk);
    chk("hold_ack1", 32'(bus.Ack), 1);
    @(negedge Clk);
    chk("hold_gap", 32'(bus.Ack), 0);
    @(negedge Clk);
    chk("hold_ack2", 32'(bus.Ack), 1);
    chk("hold_addr2", 32'(bus.MemAddr), 1);
    bus.Push = 1'b0;
    @(negedge Clk);
    chk("hold_sp", 32'(sp), 2);
    @(negedge Clk);
    chk("hold_idle", 32'(bus.Busy), 0);
    push_op(8'h88, 2, 1'b0);
    chk("hold_not_full", 32'(bus.Full), 0);
    push_op(8'h99, 3, 1'b0);
    chk("hold_full", 32'(bus.Full), 1);
    pop_op(3, 8'h99, 1'b0, 1'b0);
    pop_op(2, 8'h88, 1'b0, 1'b0);
    pop_op(1, 8'h77, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Sequencing controller for the push-down stack: arbitrates Push/Pop/Clear requests and drives the up/down stack-pointer counter (direction, enable, clear) and a synchronous single-port stack RAM. It tracks occupancy internally to produce Full/Empty and reject illegal operations with an error pulse. It sits between the stack's user interface and the pointer-counter + RAM datapath.

Parameters:
ADDR_WIDTH, 10, pointer/RAM address width; DEPTH = 2**ADDR_WIDTH entries
DATA_WIDTH, 8, stack word width

Ports:
Clk  in  1  rising-edge clock
Rst  in  1  asynchronous, active-high reset
Push  in  1  push request (level, held until Ack)
Pop  in  1  pop request (level, held until Ack)
Clear  in  1  empty-stack request (level, held until Ack)
DataIn  in  DATA_WIDTH  word to push, sampled when Push accepted in IDLE
DataOut  out  DATA_WIDTH  last popped word, registered
Ack  out  1  one-cycle completion strobe for accepted or rejected request
Err  out  1  one-cycle strobe with Ack when request rejected
Busy  out  1  high whenever state != IDLE
Full  out  1  Count == DEPTH
Empty  out  1  Count == 0
CntD  out  1  counter direction: 1 up, 0 down
CntE  out  1  counter enable, one cycle per step
CntRst  out  1  counter clear
Sp  in  ADDR_WIDTH  current counter value (next-free slot address)
MemAddr  out  ADDR_WIDTH  RAM address (= Sp)
MemWe  out  1  RAM write enable
MemWdata  out  DATA_WIDTH  RAM write data
MemRdata  in  DATA_WIDTH  RAM read data, valid one cycle after address

Behaviour:
- Reset (Rst high, async): state IDLE, Count=0, DataOut=0, held data reg=0, Ack=Err=0, CntE=0, CntD=0, MemWe=0; Empty=1, Full=0, Busy=0; CntRst=1 combinationally while Rst high. Reset mid-operation aborts with no Ack.
- Count: internal ADDR_WIDTH+1-bit register, 0..DEPTH; never wraps.
- States: IDLE, PUSH, POP_DEC, POP_RD, POP_OUT, CLEAR, REJECT.
- IDLE sampling priority: Clear > Pop > Push. Requests ignored outside IDLE.
- IDLE->CLEAR on Clear. CLEAR (1 cycle): CntRst=1, Count<=0, Ack=1 -> IDLE.
- IDLE & Pop: Empty -> REJECT; else POP_DEC.
- IDLE & Push (no Pop/Clear): Full -> REJECT; else latch DataIn, -> PUSH.
- PUSH (1 cycle): MemAddr=Sp, MemWe=1, MemWdata=latched word, CntE=1, CntD=1, Count<=Count+1, Ack=1 -> IDLE. Ack 1 cycle after acceptance.
- POP_DEC: CntE=1, CntD=0, Count<=Count-1 -> POP_RD.
- POP_RD: MemAddr=Sp (already decremented) -> POP_OUT.
- POP_OUT: DataOut<=MemRdata, Ack=1 -> IDLE. Ack 3 cycles after acceptance.
- REJECT (1 cycle): Ack=1, Err=1; no counter, RAM, Count or DataOut change -> IDLE.
- CntE, MemWe, Ack, Err asserted only in the listed states; CntD=0 outside PUSH. CntRst=Rst | (state==CLEAR).
- Sp wrap: push at Sp=DEPTH-1 makes Sp=0 with Count=DEPTH (Full); next pop decrements Sp to DEPTH-1. Addressing uses Sp only; Full/Empty use Count only.
- Handshake: requester drops request the cycle after seeing Ack; controller re-samples in the following IDLE cycle, so a request held past Ack is a new operation.
- Full, Empty, Busy decoded from registered state/Count (glitch-free, no input paths).

Test Plan:
- ADDR_WIDTH=2: reset, push 0x11,0x22,0x33,0x44 -> each Ack 1 cycle after acceptance, MemWe at Sp=0..3, Full=1 after 4th, Sp=0.
- Push 0x55 while Full -> Ack+Err one cycle, no MemWe/CntE, Full stays 1.
- Pop x4 from full -> DataOut 0x44,0x33,0x22,0x11, each Ack 3 cycles after acceptance, Empty=1 at end; 5th Pop -> Ack+Err, DataOut stays 0x11.
- Push and Pop both high in IDLE with Count=2 -> pop performed, Count=1; Clear+Pop high -> CLEAR, CntRst one cycle, Count=0, Empty=1.
- Assert Rst during POP_RD -> immediate IDLE, Count=0, DataOut=0, CntRst=1, no Ack.
- Hold Push through Ack for one extra cycle -> second push occurs, Count increments by 2.
